// File: rtl/matrix_mul_tile_pkg.sv
// Shared definitions for the matrix multiply tile: FSM encoding and default geometry.
// ACC_WIDTH is derived in each module from these defaults.
package matrix_mul_tile_pkg;

  localparam int DEF_N          = 3;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

endpackage

// File: rtl/matrix_mul_tile_mac.sv
// One output-column lane: signed/unsigned DATA_WIDTH multiply into a wrapping ACC_WIDTH accumulator.
// Updates only when en_i is high; load_i replaces the running sum with init_i before adding.
module mac_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 22
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [ACC_WIDTH-1:0]  init_i,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic signed [DATA_WIDTH:0]   a_ext;
  logic signed [DATA_WIDTH:0]   b_ext;
  logic signed [ACC_WIDTH-1:0]  prod;
  logic        [ACC_WIDTH-1:0]  acc_d;
  logic        [ACC_WIDTH-1:0]  acc_q;

  // One extra bit turns unsigned operands into non-negative signed ones; the product
  // is only ever needed modulo 2^ACC_WIDTH, so operands are cast straight to that width.
  assign a_ext = {signed_i & a_i[DATA_WIDTH-1], a_i};
  assign b_ext = {signed_i & b_i[DATA_WIDTH-1], b_i};
  assign prod  = ACC_WIDTH'(a_ext) * ACC_WIDTH'(b_ext);
  assign acc_d = (load_i ? init_i : acc_q) + ACC_WIDTH'(prod);
  assign acc_o = acc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_mul_tile.sv
// N x N tile multiply C = A*B (+ previous C), one row per N MAC cycles plus a writeback cycle.
// A row is held on the output until out_ready; in_ready only between tiles.
module matrix_mul_tile
  import matrix_mul_tile_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N) + 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N*N*DATA_WIDTH-1:0]   tensor_data,
  input  logic [N*N*DATA_WIDTH-1:0]   weight_data,
  input  logic                        signed_mode,
  input  logic                        acc_clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N*ACC_WIDTH-1:0]      matrix_product,
  output logic [$clog2(N)-1:0]        out_row,
  output logic                        out_last
);

  localparam int RW = $clog2(N);
  localparam int KW = $clog2(N+1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N-1);
  localparam logic [KW-1:0] K_WB     = KW'(N);

  state_e                       state_q;
  logic [RW-1:0]                row_q;
  logic [KW-1:0]                k_q;
  logic [N*N*DATA_WIDTH-1:0]    a_q;
  logic [N*N*DATA_WIDTH-1:0]    b_q;
  logic                         sgn_q;
  logic                         clr_q;
  logic [N*N*ACC_WIDTH-1:0]     c_q;
  logic                         out_valid_q;
  logic                         out_last_q;
  logic [N*ACC_WIDTH-1:0]       prod_q;

  int                           k_idx;
  int                           r_idx;
  logic [DATA_WIDTH-1:0]        a_elem;
  logic [DATA_WIDTH-1:0]        b_col    [N];
  logic [ACC_WIDTH-1:0]         init_row [N];
  logic [ACC_WIDTH-1:0]         acc_row  [N];
  logic [N*ACC_WIDTH-1:0]       acc_flat;
  logic                         mac_en;
  logic                         mac_load;

  // k_q == N is the writeback cycle; clamp the operand index so it stays in range.
  always_comb begin
    k_idx    = (k_q < K_WB) ? int'(k_q) : 0;
    r_idx    = int'(row_q);
    a_elem   = a_q[(N*N-1-(r_idx*N+k_idx))*DATA_WIDTH +: DATA_WIDTH];
    acc_flat = '0;
    for (int j = 0; j < N; j++) begin
      b_col[j]    = b_q[(N*N-1-(k_idx*N+j))*DATA_WIDTH +: DATA_WIDTH];
      init_row[j] = clr_q ? '0 : c_q[(N*N-1-(r_idx*N+j))*ACC_WIDTH +: ACC_WIDTH];
      acc_flat[(N-1-j)*ACC_WIDTH +: ACC_WIDTH] = acc_row[j];
    end
  end

  assign mac_en   = (state_q == COMPUTE) && (k_q != K_WB);
  assign mac_load = (k_q == '0);

  for (genvar j = 0; j < N; j++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .en_i     (mac_en),
      .load_i   (mac_load),
      .signed_i (sgn_q),
      .a_i      (a_elem),
      .b_i      (b_col[j]),
      .init_i   (init_row[j]),
      .acc_o    (acc_row[j])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      row_q       <= '0;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      clr_q       <= 1'b0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      prod_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= tensor_data;
            b_q     <= weight_data;
            sgn_q   <= signed_mode;
            clr_q   <= acc_clear;
            row_q   <= '0;
            k_q     <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (k_q == K_WB) begin
            c_q[(N-1-r_idx)*N*ACC_WIDTH +: N*ACC_WIDTH] <= acc_flat;
            prod_q      <= acc_flat;
            out_valid_q <= 1'b1;
            out_last_q  <= (row_q == ROW_LAST);
            k_q         <= '0;
            state_q     <= OUTPUT;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (row_q == ROW_LAST) begin
              row_q   <= '0;
              state_q <= IDLE;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= COMPUTE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign out_row        = row_q;
  assign matrix_product = prod_q;

endmodule

// File: tb/tb_matrix_mul_tile.sv
// Bench for matrix_mul_tile: vector table plus stall and reset sequences, checked by a row scoreboard.
// A second instance with ACC_WIDTH=12 shares the stimulus to observe accumulator wrap.
module tb_matrix_mul_tile;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 22;
  localparam int NV = 7;

  typedef logic [N*N*DW-1:0] tile_t;
  typedef logic [N*AW-1:0]   row_t;
  typedef logic [N*N*AW-1:0] cflat_t;

  typedef struct {
    tile_t  a;
    tile_t  b;
    logic   sgn;
    logic   clr;
    logic   chk12;
    cflat_t exp;
  } vec_t;

  typedef struct {
    row_t       prod;
    logic [1:0] row;
    logic       last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  tile_t         tensor_data;
  tile_t         weight_data;
  logic          signed_mode;
  logic          acc_clear;
  logic          out_valid;
  logic          out_ready;
  row_t          matrix_product;
  logic [1:0]    out_row;
  logic          out_last;

  logic          in_ready12;
  logic          out_valid12;
  logic [N*12-1:0] mp12;
  logic [1:0]    out_row12;
  logic          out_last12;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic          chk12    = 1'b0;
  exp_t          sb[$];
  cflat_t        mc;
  vec_t          v[NV];

  always #5 clk = ~clk;

  matrix_mul_tile #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .tensor_data(tensor_data), .weight_data(weight_data),
    .signed_mode(signed_mode), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .matrix_product(matrix_product), .out_row(out_row), .out_last(out_last)
  );

  matrix_mul_tile #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(12)) dut12 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready12),
    .tensor_data(tensor_data), .weight_data(weight_data),
    .signed_mode(signed_mode), .acc_clear(acc_clear),
    .out_valid(out_valid12), .out_ready(out_ready),
    .matrix_product(mp12), .out_row(out_row12), .out_last(out_last12)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tile_t fill(input int val);
    tile_t t;
    for (int i = 0; i < N*N; i++) t[i*DW +: DW] = DW'(val);
    return t;
  endfunction

  function automatic tile_t ident();
    tile_t t = '0;
    for (int r = 0; r < N; r++) t[(N*N-1-(r*N+r))*DW +: DW] = 8'd1;
    return t;
  endfunction

  function automatic tile_t seq1();
    tile_t t;
    for (int i = 0; i < N*N; i++) t[(N*N-1-i)*DW +: DW] = DW'(i+1);
    return t;
  endfunction

  function automatic cflat_t cfill(input int val);
    cflat_t c;
    for (int i = 0; i < N*N; i++) c[i*AW +: AW] = AW'(val);
    return c;
  endfunction

  function automatic cflat_t cm(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {AW'(e0), AW'(e1), AW'(e2), AW'(e3), AW'(e4), AW'(e5), AW'(e6), AW'(e7), AW'(e8)};
  endfunction

  function automatic vec_t mkvec(input tile_t a, b, input logic sgn, clr, c12, input cflat_t exp);
    vec_t x;
    x.a = a; x.b = b; x.sgn = sgn; x.clr = clr; x.chk12 = c12; x.exp = exp;
    return x;
  endfunction

  // Reference: plain integer matrix multiply, wrapped to AW bits.
  function automatic cflat_t model(input tile_t a, b, input logic sgn, clr, input cflat_t prev);
    cflat_t res = '0;
    longint s, x, y;
    logic [DW-1:0] ea, eb;
    logic [AW-1:0] pe;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        pe = prev[(N*N-1-(r*N+c))*AW +: AW];
        s  = clr ? 64'sd0 : longint'(pe);
        for (int k = 0; k < N; k++) begin
          ea = a[(N*N-1-(r*N+k))*DW +: DW];
          eb = b[(N*N-1-(k*N+c))*DW +: DW];
          x  = sgn ? longint'($signed(ea)) : longint'(ea);
          y  = sgn ? longint'($signed(eb)) : longint'(eb);
          s += x * y;
        end
        res[(N*N-1-(r*N+c))*AW +: AW] = s[AW-1:0];
      end
    end
    return res;
  endfunction

  task automatic send_tile(input tile_t a, b, input logic sgn, clr, input cflat_t exp);
    exp_t e;
    int   w = 0;
    @(posedge clk); #1;
    tensor_data = a; weight_data = b; signed_mode = sgn; acc_clear = clr; in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("accept_wait", in_ready, 1'b1);
    for (int r = 0; r < N; r++) begin
      e.prod = exp[(N-1-r)*N*AW +: N*AW];
      e.row  = 2'(r);
      e.last = (r == N-1);
      sb.push_back(e);
    end
    mc = exp;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(posedge clk); w++;
    end
    #1;
    check("drain_rows", 32'(sb.size()), 32'd0);
    check("ready_after_tile", in_ready, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_row: got row %0d expected no row", out_row);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("row_data", matrix_product, e.prod);
        check("row_index", out_row, e.row);
        check("row_last", out_last, e.last);
        if (chk12) check("acc12_wrap", mp12, {3{12'd2563}});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    tile_t  ra, rb;
    logic   rs, rc;
    cflat_t ex;
    row_t   held;
    int     cyc;

    v[0] = mkvec(ident(), seq1(), 1'b0, 1'b1, 1'b0, cm(1, 2, 3, 4, 5, 6, 7, 8, 9));
    v[1] = mkvec(ident(), seq1(), 1'b0, 1'b0, 1'b0, cm(2, 4, 6, 8, 10, 12, 14, 16, 18));
    v[2] = mkvec(fill(255), fill(2), 1'b1, 1'b1, 1'b0, cfill(-6));
    v[3] = mkvec(fill(255), fill(2), 1'b0, 1'b1, 1'b0, cfill(1530));
    v[4] = mkvec(fill(255), fill(255), 1'b0, 1'b1, 1'b1, cfill(195075));
    v[5] = mkvec(fill(255), fill(255), 1'b1, 1'b1, 1'b0, cfill(3));
    v[6] = mkvec(ident(), fill(255), 1'b1, 1'b0, 1'b0, cfill(2));

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tensor_data = '0; weight_data = '0; signed_mode = 1'b0; acc_clear = 1'b0;
    mc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_row", out_row, 2'd0);
    check("rst_product", matrix_product, '0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < NV; i++) begin
      chk12 = v[i].chk12;
      send_tile(v[i].a, v[i].b, v[i].sgn, v[i].clr, v[i].exp);
      if (i == 0) begin
        cyc = 0;
        while (!out_valid && cyc < 20) begin
          @(posedge clk); #1; cyc++;
        end
        check("first_latency", 32'(cyc), 32'd4);
      end
      drain();
      chk12 = 1'b0;
    end

    // Stall row 1 for five cycles while offering a stray tile that must be ignored.
    ra = tile_t'({$urandom(), $urandom(), $urandom()});
    rb = tile_t'({$urandom(), $urandom(), $urandom()});
    send_tile(ra, rb, 1'b1, 1'b1, model(ra, rb, 1'b1, 1'b1, mc));
    cyc = 0;
    while (sb.size() > 2 && cyc < 100) begin
      @(posedge clk); cyc++;
    end
    #1;
    out_ready = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("stall_row_arrives", out_valid, 1'b1);
    held = sb[0].prod;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_row", out_row, 2'd1);
      check("stall_data", matrix_product, held);
      check("stall_in_ready", in_ready, 1'b0);
      tensor_data = fill(i + 7); weight_data = fill(i + 3); in_valid = (i > 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset during row 1 compute abandons the tile and clears the result store.
    ra = tile_t'({$urandom(), $urandom(), $urandom()});
    rb = tile_t'({$urandom(), $urandom(), $urandom()});
    send_tile(ra, rb, 1'b0, 1'b1, model(ra, rb, 1'b0, 1'b1, mc));
    cyc = 0;
    while (sb.size() > 2 && cyc < 100) begin
      @(posedge clk); cyc++;
    end
    #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_product", matrix_product, '0);
    sb.delete();
    mc = '0;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_mid_no_row", out_valid, 1'b0);
      check("rst_mid_in_ready", in_ready, 1'b1);
    end
    ra = tile_t'({$urandom(), $urandom(), $urandom()});
    rb = tile_t'({$urandom(), $urandom(), $urandom()});
    send_tile(ra, rb, 1'b1, 1'b0, model(ra, rb, 1'b1, 1'b1, '0));
    drain();

    for (int t = 0; t < 4; t++) begin
      ra = tile_t'({$urandom(), $urandom(), $urandom()});
      rb = tile_t'({$urandom(), $urandom(), $urandom()});
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      ex = model(ra, rb, rs, rc, mc);
      send_tile(ra, rb, rs, rc, ex);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_mul_tile.md
MATRIX_MUL_TILE -- requirements
Module: matrix_mul_tile

Interface
REQ-001 Parameter N, default 3: tile dimension; matrices are N x N; N >= 2.
REQ-002 Parameter DATA_WIDTH, default 8: operand element width.
REQ-003 Parameter ACC_WIDTH, default 2*DATA_WIDTH+$clog2(N)+4: accumulator and result element width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 in_valid  input  1  operand tile offered.
REQ-007 in_ready  output  1  block can accept a tile.
REQ-008 tensor_data  input  N*N*DATA_WIDTH  matrix A, row-major, element (r,c) at bits [(N*N-1-(r*N+c))*DATA_WIDTH +: DATA_WIDTH].
REQ-009 weight_data  input  N*N*DATA_WIDTH  matrix B, same packing.
REQ-010 signed_mode  input  1  sampled with tile; 1 = two's-complement operands, 0 = unsigned.
REQ-011 acc_clear  input  1  sampled with tile; 1 = C starts at zero, 0 = C accumulates onto the previous tile's result.
REQ-012 out_valid  output  1  result row available.
REQ-013 out_ready  input  1  consumer accepts the row.
REQ-014 matrix_product  output  N*ACC_WIDTH  row of C, element c at bits [(N-1-c)*ACC_WIDTH +: ACC_WIDTH].
REQ-015 out_row  output  $clog2(N)  index of the row on matrix_product.
REQ-016 out_last  output  1  high with out_valid on row N-1.

Function
REQ-017 FSM states: IDLE, COMPUTE, OUTPUT.
REQ-018 in_ready = 1 only in IDLE.
REQ-019 On in_valid && in_ready: A, B, signed_mode and acc_clear are registered; row counter = 0; k counter = 0; state -> COMPUTE.
REQ-020 COMPUTE row r takes exactly N cycles; in cycle k, lane j adds A[r][k]*B[k][j] to acc[j]; N lanes operate in parallel.
REQ-021 At COMPUTE entry for row r, acc[j] = 0 if acc_clear, else stored C[r][j] from the previous tile.
REQ-022 After the N-th MAC cycle, state -> OUTPUT; acc row is written into result store C[r][*]; out_valid = 1.
REQ-023 First out_valid occurs N+1 cycles after the accepting edge.
REQ-024 In OUTPUT, matrix_product, out_row and out_last stay stable until out_valid && out_ready.
REQ-025 On handshake for r < N-1: r += 1, state -> COMPUTE; on handshake for r = N-1: state -> IDLE, in_ready = 1 in the following cycle.
REQ-026 Products are sign- or zero-extended per the registered signed_mode to ACC_WIDTH; sums wrap modulo 2^ACC_WIDTH with no saturation or overflow flag.
REQ-027 in_valid asserted outside IDLE is ignored; operands are not re-sampled mid-tile.
REQ-028 out_ready asserted while out_valid = 0 has no effect.
REQ-029 Result store persists across tiles; only reset or a tile with acc_clear = 1 clears the accumulation baseline.

Reset
REQ-030 rstn low immediately forces state IDLE, in_ready = 1 after release, out_valid = 0, out_last = 0, out_row = 0, matrix_product = 0, and all counters, operand registers, accumulators and the result store to 0.
REQ-031 Reset mid-COMPUTE or mid-OUTPUT abandons the tile; no partial row is ever presented afterwards.

Structure
REQ-032 Shared package holds the FSM state encoding and the default values of DATA_WIDTH and N; ACC_WIDTH is derived locally.
REQ-033 One sub-module, mac_lane (signed/unsigned multiply plus ACC_WIDTH accumulator with load/clear), is instantiated N times via generate.

Verification
REQ-034 N=3, A=identity, B=1..9, acc_clear=1, out_ready=1 -> rows (1,2,3), (4,5,6), (7,8,9); first out_valid 4 cycles after accept; out_last on row 2 only.
REQ-035 A all 0xFF, B all 0x02: signed_mode=1 -> every element -6; signed_mode=0 -> every element 1530.
REQ-036 Tile of REQ-034 sent twice, second with acc_clear=0 -> rows (2,4,6), (8,10,12), (14,16,18).
REQ-037 out_ready held low for 5 cycles on row 1 -> out_valid, matrix_product and out_row=1 held stable; in_ready stays 0; no row lost.
REQ-038 ACC_WIDTH=12, unsigned, A=B all 0xFF -> every element 2563 (wrap of 195075).
REQ-039 rstn pulsed low during row-1 COMPUTE -> out_valid=0 at once, in_ready=1 after release; next tile with acc_clear=0 yields plain A*B.
